ram_arbiter_d0: RTL

Two-port round-robin arbiter and sequencer for a single-port, synchronous-read data RAM bank (registered read address, 1-cycle read latency).
- Lets two requesters share the bank: m0 is the core datapath, m1 is the DMA/loader.
- Issues at most one RAM access per cycle.
- Returns read data to the requester that issued the read.
- Optionally clears the bank after reset.

---
 rtl/ram_arbiter_d0_if.sv | 21 ++
 rtl/ram_arbiter_d0.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ram_arbiter_d0_if.sv
// ram_arbiter_d0_if
// Per-requester access bundle for ram_arbiter_d0.
//   req/we/addr/wdata : request from the requester (held until gnt)
//   gnt               : access accepted this cycle
//   rvalid/rdata      : read return, one cycle after a granted read
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_d0_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  logic              req;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter_d0.sv
// ram_arbiter_d0
// Two-port round-robin arbiter/sequencer for a single-port RAM bank with a
// registered read address (1-cycle read latency). m0 is the core datapath,
// m1 the DMA/loader. At most one RAM access per cycle; read data is routed
// back to the requester that issued the read.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   m0, m1              : requester buses (ram_arbiter_d0_if, slave side)
//   ram_addr/din/we     : RAM command outputs
//   ram_dout            : RAM read data (valid the cycle after the read)
//   busy                : post-reset clear sequence running, no grants
// Optional feature: define RAM_ARB_INIT_CLEAR_EN to zero the whole bank
// after every reset (DEPTH cycles, busy=1) before arbitration starts.
module ram_arbiter_d0 #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  ram_arbiter_d0_if.slave   m0,
  ram_arbiter_d0_if.slave   m1,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic {ST_CLEAR, ST_ARB} state_t;

  state_t state_reg, state_next;
  logic   last_reg;      // index of the most recently granted requester
  logic   rvalid0_reg;   // read tag: data on ram_dout this cycle belongs to m0
  logic   rvalid1_reg;   // read tag: data on ram_dout this cycle belongs to m1
  logic   gnt0, gnt1;

`ifdef RAM_ARB_INIT_CLEAR_EN
  localparam int DEPTH = 1 << AWIDTH;
  logic [AWIDTH-1:0] clr_cnt_reg;

  // State register with clear counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_CLEAR)
        clr_cnt_reg <= clr_cnt_reg + 1'b1;
    end
  end

  // Next state: leave CLEAR right after writing the last address
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_CLEAR && clr_cnt_reg == AWIDTH'(DEPTH - 1))
      state_next = ST_ARB;
  end

  assign busy = (state_reg == ST_CLEAR);
`else
  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_reg <= ST_ARB;
    else
      state_reg <= state_next;
  end

  // Next state: without the clear sequence the FSM never leaves ARB
  always_comb begin
    state_next = ST_ARB;
  end

  assign busy = 1'b0;
`endif

  // Outputs: grant and RAM command. Everything is qualified by reset_n so
  // grants and writes collapse immediately when reset is asserted.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (reset_n && state_reg == ST_ARB) begin
      // On contention the requester that was not granted last wins
      gnt0 = m0.req && (!m1.req || last_reg);
      gnt1 = m1.req && !gnt0;
    end
    if (gnt0) begin
      ram_we   = m0.we;
      ram_addr = m0.addr;
      ram_din  = m0.wdata;
    end else if (gnt1) begin
      ram_we   = m1.we;
      ram_addr = m1.addr;
      ram_din  = m1.wdata;
    end
`ifdef RAM_ARB_INIT_CLEAR_EN
    else if (reset_n && state_reg == ST_CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_cnt_reg;
    end
`endif
  end

  // Round-robin pointer and read-return tags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_reg    <= 1'b1;
      rvalid0_reg <= 1'b0;
      rvalid1_reg <= 1'b0;
    end else begin
      if (gnt0)
        last_reg <= 1'b0;
      else if (gnt1)
        last_reg <= 1'b1;
      rvalid0_reg <= gnt0 && !m0.we;
      rvalid1_reg <= gnt1 && !m1.we;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0_reg;
  assign m1.rvalid = rvalid1_reg;
  // RAM output is steered only to the tagged requester; the other sees zero
  assign m0.rdata  = rvalid0_reg ? ram_dout : '0;
  assign m1.rdata  = rvalid1_reg ? ram_dout : '0;

endmodule
